// File: rtl/turbo_interleaver.sv
// LTE turbo-code QPP interleaver: loads one K-bit block byte-serially, then streams
// the systematic bit c(i) and the interleaved bit c(pi(i)) one per clock.
module turbo_interleaver (
    input  logic       clk,
    input  logic       reset_async,
    input  logic [7:0] dataIn,
    input  logic       look_now_in,
    input  logic       flag_long_in,
    output logic       dataInNext,
    output logic       dataOut,
    output logic       dataOut2,
    output logic       look_now_out,
    output logic       flag_long_out
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_OUTPUT} state_t;

    state_t      state_q, state_d;
    logic        wait_cnt_q, wait_cnt_d;
    logic [9:0]  byte_cnt_q, byte_cnt_d;
    logic [12:0] out_cnt_q, out_cnt_d;
    logic [12:0] pi_q, pi_d;
    logic [12:0] g_q, g_d;
    logic        flag_q, flag_d;
    logic        din_next_q, din_next_d;
    logic        lno_q, lno_d;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [12:0] rd_addr1_d, rd_addr2_d;
    logic        rd1_q, rd2_q;
    logic        mem [0:6143];

    logic [12:0] k_val, g_init, two_f2;
    logic [9:0]  nbytes;
    logic        capture, last_out, wait_done;

    // Per-size constants: g(0) = (f1+f2) mod K and the step 2*f2 mod K.
    always_comb begin
        k_val  = flag_q ? 13'd6144 : 13'd1056;
        nbytes = flag_q ? 10'd768  : 10'd132;
        g_init = flag_q ? 13'd743  : 13'd83;
        two_f2 = flag_q ? 13'd960  : 13'd132;
    end

    function automatic logic [12:0] mod_add(input logic [12:0] a, input logic [12:0] b,
                                            input logic [12:0] k);
        logic [13:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, k}) s = s - {1'b0, k};
        return s[12:0];
    endfunction

    assign capture   = look_now_in && (state_q == S_IDLE || state_q == S_LOAD);
    assign wait_done = (state_q == S_WAIT) && wait_cnt_q;
    assign last_out  = (out_cnt_q == k_val - 13'd1);

    always_ff @(posedge clk or negedge reset_async) begin
        if (!reset_async) state_q <= S_IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (look_now_in) state_d = S_WAIT;
            S_LOAD:   if (look_now_in) state_d = S_WAIT;
            S_WAIT:   if (wait_cnt_q) state_d = (byte_cnt_q == nbytes) ? S_OUTPUT : S_LOAD;
            S_OUTPUT: if (last_out) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wait_cnt_d = 1'b0;
        byte_cnt_d = byte_cnt_q;
        out_cnt_d  = out_cnt_q;
        pi_d       = pi_q;
        g_d        = g_q;
        flag_d     = flag_q;
        din_next_d = capture;
        lno_d      = lno_q;
        wr_en      = capture;
        wr_addr    = (state_q == S_IDLE) ? 13'd0 : {byte_cnt_q, 3'b000};
        rd_addr1_d = out_cnt_q;
        rd_addr2_d = pi_q;
        case (state_q)
            S_IDLE: begin
                lno_d = 1'b0;
                if (look_now_in) begin
                    flag_d     = flag_long_in;
                    byte_cnt_d = 10'd1;
                end
            end
            S_LOAD: if (look_now_in) byte_cnt_d = byte_cnt_q + 10'd1;
            S_WAIT: begin
                wait_cnt_d = ~wait_cnt_q;
                if (wait_done && byte_cnt_q == nbytes) begin
                    lno_d      = 1'b1;
                    out_cnt_d  = 13'd0;
                    pi_d       = 13'd0;
                    g_d        = g_init;
                    rd_addr1_d = 13'd0;
                    rd_addr2_d = 13'd0;
                end
            end
            S_OUTPUT: begin
                if (last_out) begin
                    lno_d      = 1'b0;
                    byte_cnt_d = 10'd0;
                end else begin
                    // Fetch the bit for the next index so it appears with look_now_out.
                    out_cnt_d  = out_cnt_q + 13'd1;
                    pi_d       = mod_add(pi_q, g_q, k_val);
                    g_d        = mod_add(g_q, two_f2, k_val);
                    rd_addr1_d = out_cnt_d;
                    rd_addr2_d = pi_d;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_async) begin
        if (!reset_async) begin
            wait_cnt_q <= 1'b0;
            byte_cnt_q <= '0;
            out_cnt_q  <= '0;
            pi_q       <= '0;
            g_q        <= '0;
            flag_q     <= 1'b0;
            din_next_q <= 1'b0;
            lno_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            out_cnt_q  <= out_cnt_d;
            pi_q       <= pi_d;
            g_q        <= g_d;
            flag_q     <= flag_d;
            din_next_q <= din_next_d;
            lno_q      <= lno_d;
        end
    end

    // Bit memory: byte-wide write (MSB at lowest address), two synchronous bit reads.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int j = 0; j < 8; j++) mem[wr_addr + 13'(j)] <= dataIn[7 - j];
        end
        rd1_q <= mem[rd_addr1_d];
        rd2_q <= mem[rd_addr2_d];
    end

    assign dataInNext    = din_next_q;
    assign look_now_out  = lno_q;
    assign dataOut       = lno_q & rd1_q;
    assign dataOut2      = lno_q & rd2_q;
    assign flag_long_out = flag_q;

endmodule

// File: tb/tb_turbo_interleaver.sv
// Directed bench for turbo_interleaver: one-hot blocks, a byte source reacting to
// dataInNext, and a direct-formula QPP model for the expected streams.
module tb_turbo_interleaver;

    logic       clk = 1'b0;
    logic       reset_async = 1'b0;
    logic [7:0] dataIn = 8'h00;
    logic       look_now_in = 1'b0;
    logic       flag_long_in = 1'b0;
    logic       dataInNext, dataOut, dataOut2, look_now_out, flag_long_out;

    turbo_interleaver dut (
        .clk(clk), .reset_async(reset_async), .dataIn(dataIn), .look_now_in(look_now_in),
        .flag_long_in(flag_long_in), .dataInNext(dataInNext), .dataOut(dataOut),
        .dataOut2(dataOut2), .look_now_out(look_now_out), .flag_long_out(flag_long_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit fl;
        int p;
        int exp_i2;
    } vec_t;

    int   errors = 0, checks = 0;
    bit   fl_cur = 1'b0;
    int   k_cur = 1056, nb_cur = 132, p_cur = 0, stall_at = -1;
    logic [7:0] src_bytes [768];
    bit   src_en = 1'b0;
    int   src_idx = 0, pulses = 0, gap_err = 0, stall_err = 0, stall_cnt = 0;
    int   cyc = 0, last_pulse = 0;
    bit   out1 [6144];
    bit   out2 [6144];
    int   vcnt = 0, flag_err = 0, zero_err = 0;
    bit   done = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Byte source: advances on each dataInNext pulse, optional 5-cycle stall.
    always @(negedge clk) begin
        cyc++;
        if (stall_cnt > 0) begin
            if (dataInNext) stall_err++;
            stall_cnt--;
        end else if (dataInNext) begin
            if (pulses > 0 && cyc - last_pulse != 3 && stall_at < 0) gap_err++;
            pulses++;
            last_pulse = cyc;
            src_idx++;
            if (pulses == 1) flag_long_in = ~fl_cur;
            if (src_idx == stall_at) stall_cnt = 5;
        end
        look_now_in = src_en && stall_cnt == 0 && src_idx < nb_cur;
        dataIn = (src_idx < 768) ? src_bytes[src_idx] : 8'h00;
    end

    // Output monitor.
    always @(negedge clk) begin
        if (look_now_out) begin
            if (vcnt < 6144) begin
                out1[vcnt] = dataOut;
                out2[vcnt] = dataOut2;
            end
            if (flag_long_out != fl_cur) flag_err++;
            vcnt++;
        end else begin
            if (dataOut || dataOut2) zero_err++;
            if (vcnt > 0) done = 1'b1;
        end
    end

    function automatic int model_errs();
        int e = 0;
        longint f1 = fl_cur ? 263 : 17;
        longint f2 = fl_cur ? 480 : 66;
        for (int i = 0; i < k_cur; i++) begin
            longint pi = (f1 * i + f2 * i * i) % k_cur;
            if (out1[i] != (i == p_cur)) e++;
            if (out2[i] != (pi == p_cur)) e++;
        end
        return e;
    endfunction

    task automatic start_block(input bit fl, input int p, input int st);
        fl_cur = fl;
        k_cur = fl ? 6144 : 1056;
        nb_cur = k_cur / 8;
        p_cur = p;
        stall_at = st;
        for (int i = 0; i < 768; i++) src_bytes[i] = 8'h00;
        src_bytes[p / 8] = 8'h80 >> (p % 8);
        for (int i = 0; i < 6144; i++) begin
            out1[i] = 1'b0;
            out2[i] = 1'b0;
        end
        src_idx = 0; pulses = 0; gap_err = 0; stall_err = 0; stall_cnt = 0;
        vcnt = 0; flag_err = 0; zero_err = 0; done = 1'b0;
        flag_long_in = fl;
        src_en = 1'b1;
    endtask

    task automatic finish_block(input string tag, input int exp_i2);
        for (int c = 0; c < 30000 && !done; c++) @(negedge clk);
        src_en = 1'b0;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_valid_cycles"}, vcnt, k_cur);
        chk({tag, "_byte_requests"}, pulses, nb_cur);
        chk({tag, "_request_gap"}, gap_err, 0);
        chk({tag, "_flag_out"}, flag_err, 0);
        chk({tag, "_idle_zero"}, zero_err, 0);
        chk({tag, "_sys_bit"}, out1[p_cur], 1);
        chk({tag, "_intl_bit"}, out2[exp_i2], 1);
        chk({tag, "_stream_model"}, model_errs(), 0);
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{fl: 1'b0, p: 83,   exp_i2: 1};
        vecs[1] = '{fl: 1'b0, p: 298,  exp_i2: 2};
        vecs[2] = '{fl: 1'b0, p: 645,  exp_i2: 3};
        vecs[3] = '{fl: 1'b0, p: 68,   exp_i2: 4};
        vecs[4] = '{fl: 1'b1, p: 743,  exp_i2: 1};
        vecs[5] = '{fl: 1'b1, p: 2446, exp_i2: 2};

        // Reset held with a valid source: nothing may move.
        start_block(vecs[0].fl, vecs[0].p, -1);
        repeat (4) begin
            @(negedge clk);
            chk("reset_outputs", {dataInNext, dataOut, dataOut2, look_now_out, flag_long_out}, 0);
        end
        reset_async = 1'b1;
        @(negedge clk);
        chk("first_request_pulse", dataInNext, 1);
        finish_block("v0", vecs[0].exp_i2);

        for (int v = 1; v < 6; v++) begin
            start_block(vecs[v].fl, vecs[v].p, -1);
            finish_block($sformatf("v%0d", v), vecs[v].exp_i2);
        end

        // Stall mid-load.
        start_block(1'b0, 645, 50);
        finish_block("stall", 3);
        chk("stall_no_request", stall_err, 0);

        // Reset in the middle of OUTPUT, then a clean block.
        start_block(1'b0, 298, -1);
        for (int c = 0; c < 5000 && vcnt < 100; c++) @(negedge clk);
        chk("abort_reached_output", vcnt >= 100, 1);
        @(posedge clk);
        #2;
        reset_async = 1'b0;
        src_en = 1'b0;
        #1;
        chk("abort_lno_async", look_now_out, 0);
        chk("abort_data_zero", {dataOut, dataOut2, dataInNext}, 0);
        @(negedge clk);
        reset_async = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_stays_idle", {look_now_out, dataInNext}, 0);
        start_block(1'b0, 68, -1);
        finish_block("after_abort", 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/turbo_interleaver.md
# turbo_interleaver

LTE turbo-code internal interleaver for the encoder front end. It accepts one code block of K bits as a byte stream from an upstream byte source and stores the block. It then emits two bit streams, one bit per clock: the systematic (original-order) stream and the QPP-interleaved stream, c'(i) = c(π(i)), where π(i) = (f1·i + f2·i²) mod K. A companion 1024×8 synchronous ROM, input_stream, feeds the block in hardware test.

## Interface
- No parameters. Block sizes are fixed:
  - flag_long_in=0: K=1056, f1=17, f2=66, 132 bytes.
  - flag_long_in=1: K=6144, f1=263, f2=480, 768 bytes.
- clk  in  1  single clock, rising edge.
- reset_async  in  1  asynchronous, active-low reset.
- dataIn  in  8  current input byte; bit 7 is the first bit of the byte (MSB-first).
- look_now_in  in  1  source has valid data on dataIn.
- flag_long_in  in  1  block-size select; latched at first-byte capture.
- dataInNext  out  1  registered one-cycle pulse: a byte was consumed, advance the source.
- dataOut  out  1  systematic bit c(i).
- dataOut2  out  1  interleaved bit c(π(i)).
- look_now_out  out  1  dataOut/dataOut2 valid this cycle.
- flag_long_out  out  1  latched block size of the block being output.
- input_stream (companion): address in 10, clock in 1, q out 8. Address is registered and q reflects the address sampled at the previous edge (1-cycle latency).

## Operation
- States: IDLE, LOAD, WAIT, OUTPUT.
- IDLE:
  - On an edge with look_now_in=1, capture dataIn as byte 0.
  - Latch flag_long_in and select K/f1/f2.
  - Pulse dataInNext and go to WAIT.
- WAIT: hold 2 cycles so the source can advance its address and the ROM can re-read. Then go to LOAD.
- LOAD:
  - On an edge with look_now_in=1, write byte n to bit memory at bits 8n..8n+7. Bit 7 is stored at 8n.
  - Pulse dataInNext and go to WAIT.
  - dataInNext is also pulsed after the last byte; no further byte is sampled.
  - If look_now_in=0, stay in LOAD.
- After byte K/8−1 is written, go to OUTPUT.
- OUTPUT: for i = 0..K−1, one bit per cycle, present dataOut=c(i), dataOut2=c(π(i)), look_now_out=1, flag_long_out=latched flag. Then return to IDLE; the next block may start immediately.
- π is generated incrementally, with no multipliers:
  - π(0)=0 and g(0)=(f1+f2) mod K.
  - π(i+1)=(π(i)+g(i)) mod K and g(i+1)=(g(i)+2·f2) mod K.
  - Each modular add is a single compare-subtract on a 13-bit value.
- Bit memory is 6144 bits, written one byte per write and read through two independent bit ports. Memory is not cleared by reset.
- flag_long_in changes after the first-byte capture are ignored until the next IDLE.

## Timing
- Reset (async, reset_async=0): state=IDLE, counters=0, and all outputs =0 (dataInNext, dataOut, dataOut2, look_now_out, flag_long_out). Reset mid-load or mid-output aborts the block; no partial output follows.
- Byte capture at edge T: dataInNext=1 during cycle T..T+1. The next byte is sampled no earlier than edge T+3, so there are 3 cycles per byte at full rate.
- Output latency: the last byte is captured at edge L. The first valid output (look_now_out=1, i=0) is in the cycle after edge L+2. look_now_out stays high for exactly K consecutive cycles.
- dataOut and dataOut2 are 0 whenever look_now_out=0.

## Test plan
- Reset: hold reset_async=0 with look_now_in=1 → all outputs 0, no dataInNext. Release → first dataInNext pulse one cycle after the first capture edge.
- K=1056, bytes all 0x00 except byte 10=0x10 (c(83)=1) → 132 dataInNext pulses, each 3 cycles apart. Then 1056 valid cycles with dataOut=1 only at i=83 and dataOut2=1 only at i=1, since π(1)=83. flag_long_out=0.
- K=1056 permutation check with one-hot input at bit p, for p=298, 645 and 68 in turn → dataOut2=1 at i=2, 3 and 4 respectively.
- K=6144 (flag_long_in=1), one-hot at bit 743, then at bit 2446 → 768 byte requests. dataOut2 high at i=1, then at i=2. flag_long_out=1 for all 6144 valid cycles.
- Stalls: drop look_now_in for 5 cycles mid-load → no capture and no dataInNext during the stall. The output stream is identical to the unstalled run.
- Back-to-back blocks, plus a reset asserted mid-OUTPUT → second block is output correctly. After the reset, look_now_out drops asynchronously and the next block starts cleanly from IDLE.
